// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data-memory responder with a valid/ready
// request channel, LATENCY wait states and a held response.
// Optional feature macro: DMEM_ERR_CHECK_EN. When it is defined, misaligned
// or out-of-range requests get resp_err=1 and leave the array untouched.
// When it is not defined, resp_err stays 0 and the word index wraps modulo DEPTH.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            bad_q, bad_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            access_s;
  logic            mem_we_s;
  logic            addr_bad_s;
  logic [31:0]     mem [DEPTH];

`ifdef DMEM_ERR_CHECK_EN
  // A request is rejected when it is misaligned or beyond the array.
  assign addr_bad_s = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
`else
  // Byte offset and upper address bits are deliberately ignored (index wraps).
  logic unused_addr_s;
  assign addr_bad_s    = 1'b0;
  assign unused_addr_s = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Next-state logic: accept in IDLE, count wait states, hold response until taken.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    bad_d    = bad_q;
    access_s = 1'b0;
    case (state_q)
      IDLE: begin
        // req_ready_q is only high in IDLE outside reset, so it gates acceptance.
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          idx_d   = req_addr[AW+1:2];
          wdata_d = req_wdata;
          bad_d   = addr_bad_s;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access_s = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = WAIT;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered handshake and response outputs.
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    rdata_d      = rdata_q;
    err_d        = err_q;
    mem_we_s     = 1'b0;
    if (access_s) begin
      err_d = bad_q;
      if (we_q || bad_q) begin
        rdata_d = 32'h0000_0000;
      end else begin
        rdata_d = mem[idx_q];
      end
      // A reset landing on the access edge drops the store.
      mem_we_s = we_q && !bad_q && !reset;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // State, request latch and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 32'h0000_0000;
      bad_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0000_0000;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      bad_q        <= bad_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Memory array write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: reset values, table vectors,
// stall / reset-abort / throughput sequences, and random traffic checked
// against a word-indexed associative-array model of the memory.
module tb_dmem_responder;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [int];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
    return (a % 4 != 0) || (a >= 4 * DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // One complete transaction; checks latency, data against the model, and hold behaviour.
  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int stall, output logic [31:0] rd, output bit er);
    int n;
    logic [31:0] exp;
    bit known;
    known = 1'b1;
    exp   = 32'h0;
    if (!is_bad(addr) && !we) begin
      if (model.exists(widx(addr))) exp = model[widx(addr)];
      else known = 1'b0;
    end
    resp_ready = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    check("latency", n, LATENCY);
    rd = resp_rdata;
    er = resp_err;
    if (known) check("rdata_model", rd, exp);
    check("err_model", {31'b0, er}, {31'b0, is_bad(addr)});
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom;
      @(posedge clk); #1;
      check("hold_valid", {31'b0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, rd);
      check("hold_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("consumed_valid", {31'b0, resp_valid}, 32'd0);
    check("consumed_ready", {31'b0, req_ready}, 32'd1);
    if (we && !is_bad(addr)) model[widx(addr)] = wdata;
  endtask

  initial begin : main
    logic [31:0] rd;
    bit er;
    int last, n;
    bit w;
    logic [31:0] a, d;

    // Vectors with expected outputs for the default and error-check builds.
`ifdef DMEM_ERR_CHECK_EN
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0100, 32'h0000_0077, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h0000_0099, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0100, 32'h0000_0077, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0099, 1'b0});
`else
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0104, 32'h0000_0055, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,         32'h0000_0055, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0007, 32'h0,         32'h0000_0055, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0003, 32'h0,         32'h1111_1111, 1'b0});
`endif

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, i % 2, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
    end

    // Long stall on a load response with req_valid pulses.
    do_txn(1'b0, 32'h0000_0010, 32'h0, 5, rd, er);
    check("stall_rdata", rd, 32'hDEAD_BEEF);

    // Reset during WAIT of a store: the store must be dropped.
    do_txn(1'b1, 32'h0000_0020, 32'hAAAA_AAAA, 0, rd, er);
    do_txn(1'b0, 32'h0000_0010, 32'h0, 0, rd, er);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0020; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_req_ready", {31'b0, req_ready}, 32'd0);
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("abort_rdata", resp_rdata, 32'h0);
    check("abort_err", {31'b0, resp_err}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_ready_back", {31'b0, req_ready}, 32'd1);
    do_txn(1'b0, 32'h0000_0020, 32'h0, 0, rd, er);
    check("abort_preserved", rd, 32'hAAAA_AAAA);

    // Back-to-back loads with resp_ready tied high: the period is the
    // accept-to-valid latency plus the response cycle plus the idle cycle.
    resp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010;
    last = -1;
    for (int c = 0; c < 26; c++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) begin
        check("b2b_rdata", resp_rdata, 32'hDEAD_BEEF);
        if (last >= 0) check("b2b_period", c - last, LATENCY + 2);
        last = c;
      end
    end
    check("b2b_seen", {31'b0, last >= 0}, 32'd1);
    req_valid = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    resp_ready = 1'b0;
    check("b2b_drain", {31'b0, req_ready}, 32'd1);

    // Random traffic against the model.
    for (int t = 0; t < 150; t++) begin
      w = 1'($urandom);
      a = 32'($urandom_range(0, 8 * DEPTH - 1));
      d = $urandom;
      do_txn(w, a, d, $urandom_range(0, 2), rd, er);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
